// File: rtl/demux_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared channel count, select width and slot state type.
// Revision : 1.0
// ============================================================================
package demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_out_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demux_out_slot
// Purpose  : One-entry output holding register with valid FSM and beat counter.
// Revision : 1.0
// ============================================================================
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] cnt
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_deliver;

    assign w_deliver = (r_state == SLOT_FULL) && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (load)                   w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_deliver && !load)     w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // The top only asserts load when the slot is empty or draining this edge,
    // so a held beat is never overwritten while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (load) begin
                r_data <= din;
            end
            if (w_deliver && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = (r_state == SLOT_FULL);
    assign dout      = r_data;
    assign cnt       = r_cnt;

endmodule
`default_nettype wire

// File: rtl/demux_1_4_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : demux_1_4_stream
// Purpose  : Routes one valid/ready stream to one of four registered sinks.
// Revision : 1.0
// ============================================================================
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    output logic [N_CH-1:0]  out_valid,
    input  logic [N_CH-1:0]  out_ready,
    output logic [W-1:0]     y0,
    output logic [W-1:0]     y1,
    output logic [W-1:0]     y2,
    output logic [W-1:0]     y3,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    logic             w_acc;
    logic [N_CH-1:0]  w_load;
    logic [W-1:0]     w_y   [N_CH];
    logic [CNT_W-1:0] w_cnt [N_CH];

    // Readiness looks only at the addressed channel, so a stalled sink
    // blocks just the beats destined for it.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign w_acc    = in_valid & in_ready;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign w_load[i] = w_acc && (in_sel == SEL_W'(i));

            demux_out_slot #(
                .W     (W),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (w_load[i]),
                .din       (in_data),
                .out_ready (out_ready[i]),
                .out_valid (out_valid[i]),
                .dout      (w_y[i]),
                .cnt       (w_cnt[i])
            );
        end
    endgenerate

    assign y0   = w_y[0];
    assign y1   = w_y[1];
    assign y2   = w_y[2];
    assign y3   = w_y[3];
    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
    assign cnt2 = w_cnt[2];
    assign cnt3 = w_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_demux_1_4_stream
// Purpose  : Directed self-checking bench for demux_1_4_stream (CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_demux_1_4_stream;

    localparam int W     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [W-1:0]     y0, y1, y2, y3;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    logic [W-1:0]     w_y   [4];
    logic [CNT_W-1:0] w_cnt [4];

    int n_vec = 0;
    int n_err = 0;

    demux_1_4_stream #(.W(W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    always #5 clk = ~clk;

    always_comb begin
        w_y[0] = y0;     w_y[1] = y1;     w_y[2] = y2;     w_y[3] = y3;
        w_cnt[0] = cnt0; w_cnt[1] = cnt1; w_cnt[2] = cnt2; w_cnt[3] = cnt3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-channel reference slot plus hold-stability tracking, sampled mid-cycle.
    logic       sb_has   [4];
    logic [3:0] sb_data  [4];
    logic       prev_stall [4];
    logic [3:0] prev_y   [4];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                sb_has[i]     = 1'b0;
                sb_data[i]    = '0;
                prev_stall[i] = 1'b0;
                prev_y[i]     = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (prev_stall[i]) begin
                    chk($sformatf("hold_valid_ch%0d", i), {31'b0, out_valid[i]}, 32'd1);
                    chk($sformatf("hold_data_ch%0d", i), {28'b0, w_y[i]}, {28'b0, prev_y[i]});
                end
                if (out_valid[i] && out_ready[i]) begin
                    chk($sformatf("sb_has_ch%0d", i), {31'b0, sb_has[i]}, 32'd1);
                    chk($sformatf("sb_order_ch%0d", i), {28'b0, w_y[i]}, {28'b0, sb_data[i]});
                    sb_has[i] = 1'b0;
                end
                prev_stall[i] = out_valid[i] && !out_ready[i];
                prev_y[i]     = w_y[i];
            end
            if (in_valid && in_ready) begin
                chk("sb_overwrite", {31'b0, sb_has[in_sel]}, 32'd0);
                sb_has[in_sel]  = 1'b1;
                sb_data[in_sel] = in_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'h0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
        chk("rst_y0", {28'b0, y0}, 32'd0);
        chk("rst_cnt0", {30'b0, cnt0}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // All sinks ready: one beat per channel on consecutive cycles.
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i);
            in_data  = 4'(10 + i);
            #1;
            chk($sformatf("t2_in_ready_%0d", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("t2_valid_%0d", i), {31'b0, out_valid[i]}, 32'd1);
            chk($sformatf("t2_y_%0d", i), {28'b0, w_y[i]}, 32'd10 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("t2_drained", {28'b0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_cnt_%0d", i), {30'b0, w_cnt[i]}, 32'd1);
        end

        // Stall channel 1 with 5 held, then a beat for channel 1 must wait.
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'd5;
        #1;
        chk("t3_ready_empty", {31'b0, in_ready}, 32'd1);
        tick();
        chk("t3_y1_5", {28'b0, y1}, 32'd5);
        in_data = 4'd6;
        #1;
        chk("t3_ready_blocked", {31'b0, in_ready}, 32'd0);
        tick();
        chk("t3_y1_hold", {28'b0, y1}, 32'd5);
        chk("t3_valid1_hold", {31'b0, out_valid[1]}, 32'd1);

        // Channel 3 proceeds while channel 1 is stalled.
        in_sel  = 2'd3;
        in_data = 4'd9;
        #1;
        chk("t4_ready_other", {31'b0, in_ready}, 32'd1);
        tick();
        chk("t4_y3", {28'b0, y3}, 32'd9);
        chk("t4_valid", {28'b0, out_valid}, 32'b1010);
        chk("t4_y1_unchanged", {28'b0, y1}, 32'd5);

        // Release channel 1: 5 leaves and 6 enters on the same edge.
        out_ready = 4'hF;
        in_sel    = 2'd1;
        in_data   = 4'd6;
        #1;
        chk("t3_ready_release", {31'b0, in_ready}, 32'd1);
        tick();
        chk("t3_y1_6", {28'b0, y1}, 32'd6);
        chk("t3_valid_b2b", {28'b0, out_valid}, 32'b0010);
        chk("t3_cnt1", {30'b0, cnt1}, 32'd2);
        chk("t4_cnt3", {30'b0, cnt3}, 32'd2);
        in_valid = 1'b0;
        tick();
        chk("t3_cnt1_sat", {30'b0, cnt1}, 32'd3);
        chk("t3_empty", {28'b0, out_valid}, 32'd0);

        // Park 7 in channel 2, then idle with unknown select/data.
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 4'd7;
        tick();
        in_valid = 1'b0;
        in_sel   = 2'bxx;
        in_data  = 4'bxxxx;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_valid_%0d", k), {28'b0, out_valid}, 32'b0100);
            chk($sformatf("t6_ys_%0d", k), {16'b0, y3, y2, y1, y0}, 32'h976A);
            chk($sformatf("t6_xfree_%0d", k),
                {31'b0, $isunknown({out_valid, y0, y1, y2, y3, cnt0, cnt1, cnt2, cnt3})}, 32'd0);
        end

        // Asynchronous reset mid-cycle with channel 2 full.
        in_sel  = 2'd0;
        in_data = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_valid", {28'b0, out_valid}, 32'd0);
        chk("t1_ys", {16'b0, y3, y2, y1, y0}, 32'd0);
        chk("t1_cnts", {24'b0, cnt3, cnt2, cnt1, cnt0}, 32'd0);
        chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Counter saturation on channel 0 at 2^CNT_W-1 = 3.
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        for (int k = 0; k < 5; k++) begin
            in_data = 4'(k + 1);
            tick();
            chk($sformatf("t5_y0_%0d", k), {28'b0, y0}, 32'(k + 1));
            if (k > 0) begin
                chk($sformatf("t5_cnt0_%0d", k), {30'b0, cnt0}, (k > 3) ? 32'd3 : 32'(k));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("t5_cnt0_final", {30'b0, cnt0}, 32'd3);
        chk("t5_cnt1_idle", {30'b0, cnt1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
